fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the control decoder.
- Owns the program counter and drives the instruction-memory address.
- Presents the fetched 9-bit instruction to the decoder; its top 3 bits are the opcode.
- Redirects the PC on taken branches through a target lookup table, detects program end, and reports Done plus a run-cycle count to the testbench harness.

Parameters:
- PC_W, 10, program counter / instruction-memory address width.
- INSTR_W, 9, instruction width; opcode = Instr[INSTR_W-1 -: 3].
- SEL_W, 5, branch-target selector width; selects 1 of 2^SEL_W LUT entries.
- HALT_INSTR, 9'h1FF, reserved encoding that ends the program.
- CNT_W, 16, cycle-counter width.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clk.
- Start  in  1  single-cycle pulse that begins execution at PC 0.
- Stall  in  1  hold the PC and current instruction this cycle.
- BranchTaken  in  1  from control/ALU: the current instruction is a branch and its condition holds.
- TargetSel  in  SEL_W  LUT index; the decoder supplies Instr[SEL_W-1:0] of the J-type branch.
- ImemAddr  out  PC_W  instruction-memory address, equal to PC.
- ImemData  in  INSTR_W  instruction memory read data; combinational (asynchronous ROM).
- Instr  out  INSTR_W  instruction to the decoder; equals ImemData while InstrValid=1, else 0.
- InstrValid  out  1  high only in RUN.
- PC  out  PC_W  current program counter.
- Done  out  1  registered; high in HALT.
- CycleCount  out  CNT_W  number of RUN cycles since the last Start.

Behaviour:
- States: IDLE, RUN, HALT.
- Reset (any state, including mid-RUN): state=IDLE, PC=0, Done=0, CycleCount=0, InstrValid=0, Instr=0.
- IDLE:
  - All outputs hold reset values.
  - Start=1 -> RUN next cycle with PC=0 and CycleCount=0.
  - Stall and BranchTaken are ignored.
- RUN:
  - Each cycle, CycleCount increments, saturating at all-ones; it increments on stalled cycles too.
  - Next-PC priority on each edge:
    1. Stall=1 -> PC holds.
    2. Else Instr==HALT_INSTR -> state=HALT, PC holds, Done=1 next cycle.
    3. Else BranchTaken=1 -> PC = LUT[TargetSel].
    4. Else PC = PC+1.
- Stall and BranchTaken in the same cycle: the stall wins and the branch is not latched. The decoder re-asserts BranchTaken on the following cycle because Instr is unchanged.
- HALT_INSTR with BranchTaken=1: halt wins.
- PC overflow: if PC is all-ones and the next PC would be PC+1 (no branch, no stall), go to HALT. The PC never wraps to 0. A branch from the last address is legal.
- Start during RUN is ignored.
- HALT:
  - Done=1, InstrValid=0, PC and CycleCount hold.
  - Start=1 -> RUN with PC=0, CycleCount=0, Done=0 on the next cycle.
- Fetch latency: 0 cycles. Instr and InstrValid are combinational from PC and state; there is no registered instruction.
- Branch penalty: 0 cycles. The new PC takes effect on the edge after BranchTaken.
- LUT contents are fixed at elaboration: entry k = k*16 by default, truncated to PC_W. The LUT is overridable via a memory-init file.

Decomposition:
- Package fetch_pkg:
  - state enum {IDLE, RUN, HALT}.
  - PC_W, INSTR_W, SEL_W constants.
  - HALT_INSTR.
  - Opcode localparams OP_ADD=3'b000, OP_ROR=3'b001, OP_NAND=3'b010, OP_LOAD=3'b011, OP_STORE=3'b100, OP_MOVE=3'b101, OP_BNE=3'b110, OP_SET=3'b111. These are shared with the decoder.
- Sub-module branch_lut: a combinational 2^SEL_W x PC_W ROM, inputs TargetSel, output Target.

Test Plan:
- Reset, then Start; sequential ROM, no branch, no stall -> PC reads 0,1,2,3 on successive cycles; InstrValid=1 from the cycle after Start; ImemAddr==PC.
- At PC=5, BranchTaken=1 with TargetSel=3 -> PC=48 next cycle, then 49.
- At PC=7, Stall=1 for 2 cycles with BranchTaken=1 on the first -> PC stays 7 for both; the branch is taken only when BranchTaken is re-asserted unstalled; CycleCount still increments by 2.
- Instr 9'h1FF at PC=10 with BranchTaken=1 -> HALT; Done=1 next cycle; PC=10; CycleCount frozen at 11; a Start pulse restarts at PC=0 with Done=0.
- PC=1023 with a non-branch instruction -> HALT and Done=1; PC does not wrap. Separately, BranchTaken at PC=1023 -> PC goes to the LUT target.
- Reset asserted mid-RUN at PC=20 -> next cycle IDLE, PC=0, Done=0, CycleCount=0, InstrValid=0; Start during RUN has no effect on PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; opcode encodings are also consumed by the decoder.
package fetch_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned LUT_N   = 1 << SEL_W;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ROR   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_MOVE  = 3'b101;
  localparam logic [2:0] OP_BNE   = 3'b110;
  localparam logic [2:0] OP_SET   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_e;

  // Default branch table: entry k points at address k*16, truncated to the PC width.
  function automatic logic [LUT_N*PC_W-1:0] default_lut();
    logic [LUT_N*PC_W-1:0] lut;
    lut = '0;
    for (int unsigned k = 0; k < LUT_N; k++) begin
      lut[k*PC_W +: PC_W] = PC_W'(k * 16);
    end
    return lut;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target ROM; contents come from the flattened LUT_INIT image.
module branch_lut
  import fetch_pkg::*;
#(
  parameter logic [LUT_N*PC_W-1:0] LUT_INIT = default_lut()
) (
  input  logic [SEL_W-1:0] TargetSel,
  output logic [PC_W-1:0]  Target
);

  logic [PC_W-1:0] rom [LUT_N];

  always_comb begin
    for (int unsigned k = 0; k < LUT_N; k++) begin
      rom[k] = LUT_INIT[k*PC_W +: PC_W];
    end
  end

  assign Target = rom[TargetSel];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, redirects on taken branches, detects program end
// and counts run cycles for the harness.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [LUT_N*PC_W-1:0] LUT_INIT = default_lut()
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [SEL_W-1:0]   TargetSel,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  output logic [PC_W-1:0]    PC,
  output logic               Done,
  output logic [CNT_W-1:0]   CycleCount
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   target;
  logic              running;

  branch_lut #(
    .LUT_INIT(LUT_INIT)
  ) u_lut (
    .TargetSel(TargetSel),
    .Target   (target)
  );

  assign running    = (state_q == RUN);
  assign InstrValid = running;
  assign Instr      = running ? ImemData : '0;
  assign ImemAddr   = pc_q;
  assign PC         = pc_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        // Stall beats halt beats branch; falling off the last address halts instead of wrapping.
        if (Stall) begin
          pc_d = pc_q;
        end else if (ImemData == HALT_INSTR) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else if (BranchTaken) begin
          pc_d = target;
        end else if (pc_q == '1) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random stimulus,
// all compared against a flag/integer behavioural model of the fetch rules.
module tb_fetch_unit;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Stall;
  logic       BranchTaken;
  logic [4:0] TargetSel;
  logic [9:0] ImemAddr;
  logic [8:0] ImemData;
  logic [8:0] Instr;
  logic       InstrValid;
  logic [9:0] PC;
  logic       Done;
  logic [15:0] CycleCount;

  logic [8:0] rom [1024];

  int unsigned tests;
  int unsigned failed;

  // Reference model state
  bit          m_run;
  bit          m_done;
  int unsigned m_pc;
  int unsigned m_cnt;

  fetch_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Stall      (Stall),
    .BranchTaken(BranchTaken),
    .TargetSel  (TargetSel),
    .ImemAddr   (ImemAddr),
    .ImemData   (ImemData),
    .Instr      (Instr),
    .InstrValid (InstrValid),
    .PC         (PC),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  assign ImemData = rom[ImemAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    expect_val({tag, ".pc"},    32'(PC),         m_pc);
    expect_val({tag, ".addr"},  32'(ImemAddr),   m_pc);
    expect_val({tag, ".valid"}, 32'(InstrValid), 32'(m_run));
    expect_val({tag, ".instr"}, 32'(Instr),      m_run ? 32'(rom[m_pc]) : 32'd0);
    expect_val({tag, ".done"},  32'(Done),       32'(m_done));
    expect_val({tag, ".cnt"},   32'(CycleCount), m_cnt);
  endtask

  // Advance the model by one clock edge from the inputs currently applied.
  task automatic model_edge(input bit rst, input bit st, input bit sl, input bit br,
                            input int unsigned sel);
    if (rst) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (sl) begin
        // hold
      end else if (rom[m_pc] == 9'h1FF) begin
        m_run = 0; m_done = 1;
      end else if (br) begin
        m_pc = (sel * 16) % 1024;
      end else if (m_pc == 1023) begin
        m_run = 0; m_done = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic cyc(input string tag, input bit rst, input bit st, input bit sl,
                     input bit br, input int unsigned sel);
    Reset       = rst;
    Start       = st;
    Stall       = sl;
    BranchTaken = br;
    TargetSel   = 5'(sel);
    #1;
    expect_val({tag, ".pre_instr"}, 32'(Instr), m_run ? 32'(rom[m_pc]) : 32'd0);
    model_edge(rst, st, sl, br, sel);
    @(posedge Clk);
    #1;
    check_all(tag);
  endtask

  task automatic run_steps(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned c0;
    tests = 0; failed = 0;
    m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    Reset = 1; Start = 0; Stall = 0; BranchTaken = 0; TargetSel = '0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));

    // Reset and idle behaviour
    cyc("reset", 1, 0, 0, 0, 0);
    cyc("reset2", 1, 0, 0, 0, 0);
    cyc("idle_ignore", 0, 0, 1, 1, 7);
    expect_val("idle_pc", 32'(PC), 32'd0);

    // Sequential fetch then branch at PC 5
    cyc("start", 0, 1, 0, 0, 0);
    expect_val("start_valid", 32'(InstrValid), 32'd1);
    expect_val("start_pc", 32'(PC), 32'd0);
    for (int unsigned i = 1; i <= 5; i++) begin
      cyc("seq", 0, 0, 0, 0, 0);
      expect_val("seq_pc", 32'(PC), 32'(i));
    end
    cyc("branch", 0, 0, 0, 1, 3);
    expect_val("branch_pc", 32'(PC), 32'd48);
    cyc("after_branch", 0, 0, 0, 0, 0);
    expect_val("after_branch_pc", 32'(PC), 32'd49);

    // Stall with a simultaneous branch at PC 7
    cyc("rst_b", 1, 0, 0, 0, 0);
    cyc("start_b", 0, 1, 0, 0, 0);
    run_steps("to7", 7);
    c0 = 32'(CycleCount);
    cyc("stall_br", 0, 0, 1, 1, 2);
    cyc("stall2", 0, 0, 1, 0, 2);
    expect_val("stall_pc", 32'(PC), 32'd7);
    expect_val("stall_cnt", 32'(CycleCount), c0 + 2);
    cyc("rebranch", 0, 0, 0, 1, 2);
    expect_val("rebranch_pc", 32'(PC), 32'd32);

    // Halt instruction at PC 10 wins over branch
    rom[10] = 9'h1FF;
    cyc("rst_c", 1, 0, 0, 0, 0);
    cyc("start_c", 0, 1, 0, 0, 0);
    run_steps("to10", 10);
    cyc("halt", 0, 0, 0, 1, 1);
    expect_val("halt_done", 32'(Done), 32'd1);
    expect_val("halt_pc", 32'(PC), 32'd10);
    expect_val("halt_cnt", 32'(CycleCount), 32'd11);
    expect_val("halt_valid", 32'(InstrValid), 32'd0);
    cyc("halt_hold", 0, 0, 1, 1, 5);
    cyc("halt_hold2", 0, 0, 0, 0, 0);
    cyc("restart", 0, 1, 0, 0, 0);
    expect_val("restart_pc", 32'(PC), 32'd0);
    expect_val("restart_done", 32'(Done), 32'd0);
    rom[10] = 9'h055;

    // Start during RUN ignored; reset mid-run at PC 20
    run_steps("to15", 15);
    cyc("start_in_run", 0, 1, 0, 0, 0);
    expect_val("start_in_run_pc", 32'(PC), 32'd16);
    run_steps("to20", 4);
    expect_val("at20", 32'(PC), 32'd20);
    cyc("mid_reset", 1, 1, 0, 0, 0);
    expect_val("mid_reset_pc", 32'(PC), 32'd0);
    expect_val("mid_reset_valid", 32'(InstrValid), 32'd0);
    expect_val("mid_reset_cnt", 32'(CycleCount), 32'd0);

    // End of address space: overflow halts, branch from 1023 is legal
    cyc("start_d", 0, 1, 0, 0, 0);
    cyc("br31", 0, 0, 0, 1, 31);
    expect_val("br31_pc", 32'(PC), 32'd496);
    for (int i = 0; i < 1100 && m_pc != 1023; i++) cyc("climb", 0, 0, 0, 0, 0);
    expect_val("top_pc", 32'(PC), 32'd1023);
    cyc("overflow", 0, 0, 0, 0, 0);
    expect_val("overflow_pc", 32'(PC), 32'd1023);
    expect_val("overflow_done", 32'(Done), 32'd1);
    cyc("start_e", 0, 1, 0, 0, 0);
    cyc("br31b", 0, 0, 0, 1, 31);
    for (int i = 0; i < 1100 && m_pc != 1023; i++) cyc("climb2", 0, 0, 0, 0, 0);
    cyc("br_top", 0, 0, 0, 1, 4);
    expect_val("br_top_pc", 32'(PC), 32'd64);
    expect_val("br_top_valid", 32'(InstrValid), 32'd1);

    // Random phase with sparse halt instructions
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 39) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    for (int i = 0; i < 3000; i++) begin
      cyc("rand", ($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 31));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
